// File: rtl/rs_pkg.sv
// Shared types and default sizes for the reservation-station issue scheduler.
package rs_pkg;

    localparam int unsigned RS_ENTRIES_DEF = 8;
    localparam int unsigned TAG_W_DEF      = 6;
    localparam int unsigned PAYLOAD_W_DEF  = 32;
    localparam int unsigned IDX_W_DEF      = $clog2(RS_ENTRIES_DEF);

    typedef logic [IDX_W_DEF-1:0] rs_idx_t;

    // One RS slot: source tags with their ready bits plus the opaque micro-op.
    typedef struct packed {
        logic                     valid;
        logic [TAG_W_DEF-1:0]     tag1;
        logic                     rdy1;
        logic [TAG_W_DEF-1:0]     tag2;
        logic                     rdy2;
        logic [PAYLOAD_W_DEF-1:0] payload;
    } rs_entry_t;

    typedef enum logic {
        PICK = 1'b0,
        HOLD = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rs_issue_sched_if.sv
// Dispatch, CDB wakeup and FU issue bundle for one RS / FU port pair.
interface rs_issue_sched_if
    import rs_pkg::*;
#(
    parameter int unsigned RS_ENTRIES = RS_ENTRIES_DEF,
    parameter int unsigned TAG_W      = TAG_W_DEF,
    parameter int unsigned PAYLOAD_W  = PAYLOAD_W_DEF
);
    localparam int unsigned IDX_W = $clog2(RS_ENTRIES);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic                 flush;
    logic                 disp_valid;
    logic                 disp_ready;
    logic [TAG_W-1:0]     disp_tag1;
    logic                 disp_rdy1;
    logic [TAG_W-1:0]     disp_tag2;
    logic                 disp_rdy2;
    logic [PAYLOAD_W-1:0] disp_payload;
    logic                 cdb_valid;
    logic [TAG_W-1:0]     cdb_tag;
    logic                 iss_valid;
    logic                 iss_ready;
    logic [IDX_W-1:0]     iss_idx;
    logic [PAYLOAD_W-1:0] iss_payload;
    logic [CNT_W-1:0]     occupancy;

    // Rename/dispatch and FU side.
    modport master (
        output flush, disp_valid, disp_tag1, disp_rdy1, disp_tag2, disp_rdy2, disp_payload,
        output cdb_valid, cdb_tag, iss_ready,
        input  disp_ready, iss_valid, iss_idx, iss_payload, occupancy
    );

    // Reservation-station side.
    modport slave (
        input  flush, disp_valid, disp_tag1, disp_rdy1, disp_tag2, disp_rdy2, disp_payload,
        input  cdb_valid, cdb_tag, iss_ready,
        output disp_ready, iss_valid, iss_idx, iss_payload, occupancy
    );

endinterface

// File: rtl/rs_issue_sched_rr_pick.sv
// Rotating-priority picker: first set request at or after start, wrapping.
module rr_pick #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] gnt,
    output logic          gnt_valid
);

    always_comb begin
        logic [IW-1:0] idx;
        gnt       = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        // N is a power of two, so the IW-bit add wraps modulo N for free.
        for (int unsigned k = 0; k < N; k++) begin
            idx = start + IW'(k);
            if (!gnt_valid && req[idx]) begin
                gnt       = idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_issue_sched.sv
// RS entry manager with CDB wakeup and round-robin issue that holds its pick until the FU accepts.
module rs_issue_sched
    import rs_pkg::*;
#(
    parameter int unsigned RS_ENTRIES = RS_ENTRIES_DEF,
    parameter int unsigned TAG_W      = TAG_W_DEF,
    parameter int unsigned PAYLOAD_W  = PAYLOAD_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    rs_issue_sched_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(RS_ENTRIES);
    localparam int unsigned CNT_W = IDX_W + 1;

    rs_entry_t            entries [RS_ENTRIES];
    rs_entry_t            new_entry;
    logic [RS_ENTRIES-1:0] valid_vec;
    logic [RS_ENTRIES-1:0] req;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     lock_idx;
    logic [IDX_W-1:0]     lock_idx_d;
    logic [IDX_W-1:0]     gnt;
    logic [IDX_W-1:0]     alloc_idx;
    logic [IDX_W-1:0]     iss_idx_c;
    logic                 gnt_valid;
    logic                 iss_valid_c;
    logic                 disp_ready_c;
    logic                 disp_fire;
    logic                 iss_fire;
    logic [CNT_W-1:0]     occ_q;
    lock_state_t          state_q;
    lock_state_t          state_d;
    logic [TAG_W-1:0]     disp_tag1;
    logic [TAG_W-1:0]     disp_tag2;
    logic [TAG_W-1:0]     cdb_tag;
    logic [PAYLOAD_W-1:0] disp_payload;

    assign disp_tag1    = bus.disp_tag1;
    assign disp_tag2    = bus.disp_tag2;
    assign cdb_tag      = bus.cdb_tag;
    assign disp_payload = bus.disp_payload;

    // Request vector is built from registered state only: no wakeup bypass.
    always_comb begin
        valid_vec = '0;
        req       = '0;
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            valid_vec[i] = entries[i].valid;
            req[i]       = entries[i].valid & entries[i].rdy1 & entries[i].rdy2;
        end
    end

    always_comb begin
        alloc_idx = '0;
        for (int i = int'(RS_ENTRIES) - 1; i >= 0; i--) begin
            if (!valid_vec[i]) alloc_idx = IDX_W'(i);
        end
    end

    assign disp_ready_c = ~&valid_vec;
    assign disp_fire    = bus.disp_valid & disp_ready_c & ~bus.flush;
    assign iss_fire     = iss_valid_c & bus.iss_ready & ~bus.flush;

    // A source whose producer broadcasts in the dispatch cycle is captured as ready.
    always_comb begin
        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.tag1    = disp_tag1;
        new_entry.rdy1    = bus.disp_rdy1 | (bus.cdb_valid && (disp_tag1 == cdb_tag));
        new_entry.tag2    = disp_tag2;
        new_entry.rdy2    = bus.disp_rdy2 | (bus.cdb_valid && (disp_tag2 == cdb_tag));
        new_entry.payload = disp_payload;
    end

    rr_pick #(
        .N  (RS_ENTRIES),
        .IW (IDX_W)
    ) u_rr_pick (
        .req       (req),
        .start     (rr_ptr),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PICK;
        end else begin
            state_q <= state_d;
        end
    end

    // HOLD pins the candidate so the FU sees a stable index/payload until it accepts.
    always_comb begin
        state_d     = state_q;
        lock_idx_d  = lock_idx;
        iss_valid_c = 1'b0;
        iss_idx_c   = '0;
        case (state_q)
            PICK: begin
                iss_valid_c = gnt_valid;
                iss_idx_c   = gnt_valid ? gnt : '0;
                if (gnt_valid && !bus.iss_ready) begin
                    state_d    = HOLD;
                    lock_idx_d = gnt;
                end
            end
            HOLD: begin
                iss_valid_c = 1'b1;
                iss_idx_c   = lock_idx;
                if (bus.iss_ready) state_d = PICK;
            end
            default: state_d = PICK;
        endcase
        if (bus.flush) state_d = PICK;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            lock_idx <= '0;
            rr_ptr   <= '0;
            occ_q    <= '0;
        end else begin
            lock_idx <= lock_idx_d;
            if (iss_fire) rr_ptr <= iss_idx_c + IDX_W'(1);
            case ({disp_fire, iss_fire})
                2'b10:   occ_q <= occ_q + CNT_W'(1);
                2'b01:   occ_q <= occ_q - CNT_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // The alloc slot is always free and the issued slot always valid, so they never collide.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            if (rst || bus.flush) begin
                entries[i] <= '0;
            end else begin
                if (bus.cdb_valid && entries[i].valid) begin
                    if (entries[i].tag1 == cdb_tag) entries[i].rdy1 <= 1'b1;
                    if (entries[i].tag2 == cdb_tag) entries[i].rdy2 <= 1'b1;
                end
                if (iss_fire && (iss_idx_c == IDX_W'(i))) entries[i].valid <= 1'b0;
                if (disp_fire && (alloc_idx == IDX_W'(i))) entries[i] <= new_entry;
            end
        end
    end

    assign bus.disp_ready  = disp_ready_c;
    assign bus.iss_valid   = iss_valid_c;
    assign bus.iss_idx     = iss_idx_c;
    assign bus.iss_payload = PAYLOAD_W'(entries[iss_idx_c].payload);
    assign bus.occupancy   = occ_q;

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed bench for rs_issue_sched: dispatch, wakeup, round-robin issue, hold and flush.
module tb_rs_issue_sched;
    import rs_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    rs_issue_sched_if #(.RS_ENTRIES(8), .TAG_W(6), .PAYLOAD_W(32)) bus ();

    rs_issue_sched #(.RS_ENTRIES(8), .TAG_W(6), .PAYLOAD_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.flush        = 1'b0;
        bus.disp_valid   = 1'b0;
        bus.disp_tag1    = '0;
        bus.disp_rdy1    = 1'b0;
        bus.disp_tag2    = '0;
        bus.disp_rdy2    = 1'b0;
        bus.disp_payload = '0;
        bus.cdb_valid    = 1'b0;
        bus.cdb_tag      = '0;
        bus.iss_ready    = 1'b0;
    endtask

    task automatic disp(input logic [5:0] t1, input logic r1, input logic [5:0] t2,
                        input logic r2, input logic [31:0] p);
        bus.disp_valid   = 1'b1;
        bus.disp_tag1    = t1;
        bus.disp_rdy1    = r1;
        bus.disp_tag2    = t2;
        bus.disp_rdy2    = r2;
        bus.disp_payload = p;
    endtask

    task automatic expect_issue(input string tag, input logic [31:0] idx, input logic [31:0] pay);
        check({tag, "_valid"}, 32'(bus.iss_valid), 32'd1);
        check({tag, "_idx"}, 32'(bus.iss_idx), idx);
        check({tag, "_payload"}, bus.iss_payload, pay);
    endtask

    initial begin
        rs_idx_t exp_idx;
        quiet();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state held with no stimulus.
        for (int c = 0; c < 10; c++) begin
            check("t1_disp_ready", 32'(bus.disp_ready), 32'd1);
            check("t1_iss_valid", 32'(bus.iss_valid), 32'd0);
            check("t1_occupancy", 32'(bus.occupancy), 32'd0);
            check("t1_iss_idx", 32'(bus.iss_idx), 32'd0);
            tick();
        end

        // Single ready op: issue next cycle from entry 0, then drains.
        disp(6'd1, 1'b1, 6'd2, 1'b1, 32'hA0A0_0001);
        bus.iss_ready = 1'b1;
        tick();
        bus.disp_valid = 1'b0;
        expect_issue("t2_issue", 32'd0, 32'hA0A0_0001);
        check("t2_occ_one", 32'(bus.occupancy), 32'd1);
        tick();
        check("t2_iss_valid_drained", 32'(bus.iss_valid), 32'd0);
        check("t2_occ_zero", 32'(bus.occupancy), 32'd0);

        // Fill all 8 waiting on tag 5, then a rejected 9th.
        bus.iss_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            disp(6'd5, 1'b0, 6'd0, 1'b1, 32'(100 + i));
            tick();
        end
        check("t3_occ_full", 32'(bus.occupancy), 32'd8);
        check("t3_disp_ready_full", 32'(bus.disp_ready), 32'd0);
        check("t3_no_req", 32'(bus.iss_valid), 32'd0);
        disp(6'd5, 1'b0, 6'd0, 1'b1, 32'hDEAD_BEEF);
        tick();
        bus.disp_valid = 1'b0;
        check("t3_occ_ninth", 32'(bus.occupancy), 32'd8);
        check("t3_disp_ready_ninth", 32'(bus.disp_ready), 32'd0);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd5;
        tick();
        bus.cdb_valid = 1'b0;
        // rr_ptr is 1 after the first issue, so the sweep runs 1..7 then 0.
        bus.iss_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_idx = rs_idx_t'(1 + k);
            expect_issue("t3_drain", 32'(exp_idx), 32'(100 + int'(exp_idx)));
            tick();
        end
        check("t3_occ_drained", 32'(bus.occupancy), 32'd0);
        check("t3_iss_valid_drained", 32'(bus.iss_valid), 32'd0);

        // Move rr_ptr to 3 by issuing entry 2; entries 0 and 1 wait on tags 8 and 7.
        disp(6'd8, 1'b0, 6'd0, 1'b1, 32'd200);
        tick();
        disp(6'd7, 1'b0, 6'd0, 1'b1, 32'd201);
        tick();
        disp(6'd0, 1'b1, 6'd0, 1'b1, 32'd202);
        tick();
        bus.disp_valid = 1'b0;
        expect_issue("t4_prep", 32'd2, 32'd202);
        tick();
        check("t4_prep_occ", 32'(bus.occupancy), 32'd2);
        bus.iss_ready = 1'b0;
        disp(6'd8, 1'b0, 6'd0, 1'b1, 32'd302);
        tick();
        disp(6'd7, 1'b0, 6'd0, 1'b1, 32'd303);
        tick();
        disp(6'd7, 1'b0, 6'd0, 1'b1, 32'd304);
        tick();
        disp(6'd8, 1'b0, 6'd0, 1'b1, 32'd305);
        tick();
        bus.disp_valid = 1'b0;
        check("t4_occ_six", 32'(bus.occupancy), 32'd6);
        check("t4_no_req", 32'(bus.iss_valid), 32'd0);
        // Wake 0, 2, 5 together; from rr_ptr=3 the order is 5, 0, 2.
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd8;
        bus.iss_ready = 1'b1;
        tick();
        bus.cdb_valid = 1'b0;
        expect_issue("t4_first", 32'd5, 32'd305);
        tick();
        expect_issue("t4_second", 32'd0, 32'd200);
        tick();
        expect_issue("t4_third", 32'd2, 32'd302);
        tick();
        check("t4_iss_valid_end", 32'(bus.iss_valid), 32'd0);
        check("t4_occ_end", 32'(bus.occupancy), 32'd3);

        // Hold entry 2 under backpressure while entries 1, 3, 4 wake.
        bus.iss_ready = 1'b0;
        disp(6'd10, 1'b0, 6'd0, 1'b1, 32'd400);
        tick();
        disp(6'd0, 1'b1, 6'd0, 1'b1, 32'd402);
        tick();
        bus.disp_valid = 1'b0;
        expect_issue("t5_pick", 32'd2, 32'd402);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd7;
        tick();
        bus.cdb_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            expect_issue("t5_hold", 32'd2, 32'd402);
            tick();
        end
        bus.iss_ready = 1'b1;
        expect_issue("t5_release", 32'd2, 32'd402);
        tick();
        expect_issue("t5_after_3", 32'd3, 32'd303);
        tick();
        expect_issue("t5_after_4", 32'd4, 32'd304);
        tick();
        expect_issue("t5_after_1", 32'd1, 32'd201);
        tick();
        check("t5_iss_valid_end", 32'(bus.iss_valid), 32'd0);
        check("t5_occ_end", 32'(bus.occupancy), 32'd1);

        // Same-cycle dispatch/broadcast of tag 9 must not lose the wakeup.
        bus.iss_ready = 1'b0;
        disp(6'd9, 1'b0, 6'd0, 1'b1, 32'd502);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd9;
        tick();
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = 1'b0;
        expect_issue("t6_bypass", 32'd1, 32'd502);
        check("t6_occ_two", 32'(bus.occupancy), 32'd2);
        tick();
        expect_issue("t6_hold", 32'd1, 32'd502);
        // Flush beats the concurrent dispatch and the issue handshake.
        bus.flush     = 1'b1;
        bus.iss_ready = 1'b1;
        disp(6'd0, 1'b1, 6'd0, 1'b1, 32'h0000_0BAD);
        tick();
        quiet();
        check("t6_flush_iss_valid", 32'(bus.iss_valid), 32'd0);
        check("t6_flush_occ", 32'(bus.occupancy), 32'd0);
        check("t6_flush_disp_ready", 32'(bus.disp_ready), 32'd1);
        check("t6_flush_iss_idx", 32'(bus.iss_idx), 32'd0);
        tick();
        check("t6_flush_no_write", 32'(bus.iss_valid), 32'd0);

        // Dispatch and issue in one cycle keep occupancy flat; freed slot not reused that cycle.
        bus.iss_ready = 1'b1;
        disp(6'd0, 1'b1, 6'd0, 1'b1, 32'd600);
        tick();
        disp(6'd0, 1'b1, 6'd0, 1'b1, 32'd601);
        expect_issue("t7_a", 32'd0, 32'd600);
        check("t7_occ_a", 32'(bus.occupancy), 32'd1);
        tick();
        bus.disp_valid = 1'b0;
        expect_issue("t7_b", 32'd1, 32'd601);
        check("t7_occ_flat", 32'(bus.occupancy), 32'd1);
        tick();
        check("t7_occ_zero", 32'(bus.occupancy), 32'd0);
        check("t7_iss_valid_end", 32'(bus.iss_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
